// File: rtl/key_event_pkg.sv
// Shared event-type encoding and width helper for the key event controller.
package key_event_pkg;

  typedef enum logic [1:0] {
    EVT_RELEASE = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_LONG    = 2'b10
  } evt_type_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, tick-based debounce counter and optional hold
// counter (KEY_EVENT_LONG_PRESS_EN); emits one-cycle flip/long strobes.
module key_debounce_cell #(
  parameter int unsigned DEBOUNCE_TICKS = 10
`ifdef KEY_EVENT_LONG_PRESS_EN
  , parameter int unsigned LONG_TICKS   = 1000
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_raw,
  output logic db,
  output logic flip,
  output logic long_evt
);

  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

  logic [1:0]    sync_q;
  logic          sync;
  logic [DW-1:0] cnt;
  logic          flip_now;

  assign sync = sync_q[1];
  // The tick that would bring the count to its limit flips db directly.
  assign flip_now = tick && (sync != db) && (cnt == DW'(DEBOUNCE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      db     <= 1'b0;
      flip   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_raw};
      flip   <= flip_now;
      if (tick) begin
        if (sync == db) begin
          cnt <= '0;
        end else if (flip_now) begin
          cnt <= '0;
          db  <= ~db;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

`ifdef KEY_EVENT_LONG_PRESS_EN
  localparam int unsigned HW = $clog2(LONG_TICKS + 1);

  logic [HW-1:0] hold;
  logic          long_now;

  assign long_now = tick && db && !flip_now && (hold == HW'(LONG_TICKS - 1));

  // Saturates at LONG_TICKS so a single hold yields a single long event.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= '0;
      long_evt <= 1'b0;
    end else begin
      long_evt <= long_now;
      if (tick) begin
        if (!db || flip_now) begin
          hold <= '0;
        end else if (hold != HW'(LONG_TICKS)) begin
          hold <= hold + 1'b1;
        end
      end
    end
  end
`else
  assign long_evt = 1'b0;
`endif

endmodule

// File: rtl/key_event_ctrl.sv
// Debounced multi-key event controller with round-robin event slot.
// Long-press events are built only with KEY_EVENT_LONG_PRESS_EN defined.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned N_KEYS         = 4,
  parameter int unsigned TICK_DIV       = 50_000,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter int unsigned LONG_TICKS     = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_KEYS-1:0]            i_keys,
  output logic [N_KEYS-1:0]            o_keys_db,
  output logic                         o_evt_valid,
  input  logic                         i_evt_ready,
  output logic [idx_width(N_KEYS)-1:0] o_evt_key,
  output logic [1:0]                   o_evt_type,
  output logic                         o_evt_drop
);

  localparam int unsigned KW = idx_width(N_KEYS);
  localparam int unsigned PW = $clog2(TICK_DIV + 1);

  if (N_KEYS < 1 || N_KEYS > 16 || TICK_DIV < 1 || DEBOUNCE_TICKS < 1 || LONG_TICKS < 1)
  begin : g_bad_params
    $error("key_event_ctrl: parameter out of range");
  end

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  logic [N_KEYS-1:0] flip;
  logic [N_KEYS-1:0] long_evt;

  for (genvar g = 0; g < int'(N_KEYS); g++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef KEY_EVENT_LONG_PRESS_EN
      , .LONG_TICKS  (LONG_TICKS)
`endif
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .key_raw (i_keys[g]),
      .db      (o_keys_db[g]),
      .flip    (flip[g]),
      .long_evt(long_evt[g])
    );
  end

  logic [N_KEYS-1:0] pend;
  evt_type_t         pend_type [N_KEYS];
  evt_type_t         new_type  [N_KEYS];
  logic [N_KEYS-1:0] new_evt;
  logic [N_KEYS-1:0] grant;
  logic [N_KEYS-1:0] drop_vec;
  logic [KW-1:0]     ptr;
  logic [KW-1:0]     gidx;
  logic              any_pend;
  logic              load;

  assign load = !o_evt_valid || i_evt_ready;

  always_comb begin
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      new_evt[i]  = flip[i] || long_evt[i];
      new_type[i] = flip[i] ? (o_keys_db[i] ? EVT_PRESS : EVT_RELEASE) : EVT_LONG;
    end
  end

  always_comb begin
    int unsigned idx;
    any_pend = 1'b0;
    gidx     = '0;
    idx      = 0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      idx = (32'(ptr) + i) % N_KEYS;
      if (!any_pend && pend[idx]) begin
        any_pend = 1'b1;
        gidx     = KW'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (load && any_pend) begin
      grant[gidx] = 1'b1;
    end
  end

  // A flag granted this cycle is free, so an arriving event is not a drop.
  assign drop_vec = new_evt & pend & ~grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      o_evt_drop <= 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        pend_type[i] <= EVT_RELEASE;
      end
    end else begin
      o_evt_drop <= |drop_vec;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (new_evt[i]) begin
          pend[i]      <= 1'b1;
          pend_type[i] <= new_type[i];
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_evt_valid <= 1'b0;
      o_evt_key   <= '0;
      o_evt_type  <= EVT_RELEASE;
      ptr         <= '0;
    end else if (load) begin
      o_evt_valid <= any_pend;
      if (any_pend) begin
        o_evt_key  <= gidx;
        o_evt_type <= pend_type[gidx];
        ptr        <= (gidx == KW'(N_KEYS - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

endmodule
